// File: rtl/segre_history_file.sv
// In-order completion buffer: allocate per instruction, complete out of order, retire one entry per cycle.
// Completion-to-RF-write latency is 2 cycles; decode must stall on full_o, and taken-branch retirement flushes everything younger.
module segre_history_file #(
  parameter int WORD_SIZE = 32,
  parameter int REG_SIZE  = 5,
  parameter int HF_PTR    = 3
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 alloc_valid_i,
  output logic [HF_PTR-1:0]    alloc_id_o,
  output logic                 full_o,
  input  logic                 cmp_valid_i,
  input  logic [HF_PTR-1:0]    cmp_id_i,
  input  logic                 cmp_rf_we_i,
  input  logic [REG_SIZE-1:0]  cmp_rf_waddr_i,
  input  logic [WORD_SIZE-1:0] cmp_res_i,
  input  logic                 cmp_branch_i,
  input  logic                 cmp_tkbr_i,
  input  logic [WORD_SIZE-1:0] cmp_new_pc_i,
  output logic                 rf_we_o,
  output logic [REG_SIZE-1:0]  rf_waddr_o,
  output logic [WORD_SIZE-1:0] rf_wdata_o,
  output logic                 commit_valid_o,
  output logic [HF_PTR-1:0]    commit_id_o,
  output logic                 flush_o,
  output logic [WORD_SIZE-1:0] flush_pc_o,
  output logic                 empty_o
);

  localparam int HF_SIZE = 2 ** HF_PTR;
  localparam logic [HF_PTR:0] FULL_CNT = (HF_PTR + 1)'(HF_SIZE);

  typedef struct packed {
    logic                 we;
    logic [REG_SIZE-1:0]  waddr;
    logic [WORD_SIZE-1:0] res;
    logic                 br;
    logic                 tkbr;
    logic [WORD_SIZE-1:0] pc;
  } hf_entry_t;

  hf_entry_t          entry_q [HF_SIZE];
  logic [HF_SIZE-1:0] valid_q;
  logic [HF_SIZE-1:0] done_q;
  logic [HF_PTR-1:0]  head_q;
  logic [HF_PTR-1:0]  tail_q;
  logic [HF_PTR:0]    count_q;

  hf_entry_t head_ent;
  logic      commit_now;
  logic      flush_now;
  logic      alloc_ok;
  logic      cmp_ok;

  assign head_ent   = entry_q[head_q];
  assign commit_now = valid_q[head_q] & done_q[head_q];
  assign flush_now  = commit_now & head_ent.br & head_ent.tkbr;
  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign alloc_id_o = tail_q;
  assign alloc_ok   = alloc_valid_i & ~full_o & ~flush_now;
  assign cmp_ok     = cmp_valid_i & valid_q[cmp_id_i] & ~flush_now;

  // Payload needs no reset: it is only ever read behind a valid+done entry.
  always_ff @(posedge clk_i) begin
    if (rsn_i && cmp_ok) begin
      entry_q[cmp_id_i] <= '{we:    cmp_rf_we_i,
                             waddr: cmp_rf_waddr_i,
                             res:   cmp_res_i,
                             br:    cmp_branch_i,
                             tkbr:  cmp_tkbr_i,
                             pc:    cmp_new_pc_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      valid_q        <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      rf_we_o        <= 1'b0;
      rf_waddr_o     <= '0;
      rf_wdata_o     <= '0;
      commit_valid_o <= 1'b0;
      commit_id_o    <= '0;
      flush_o        <= 1'b0;
      flush_pc_o     <= '0;
    end else begin
      commit_valid_o <= commit_now;
      rf_we_o        <= commit_now & head_ent.we;
      flush_o        <= flush_now;

      if (commit_now) begin
        commit_id_o <= head_q;
        rf_waddr_o  <= head_ent.waddr;
        rf_wdata_o  <= head_ent.res;
      end
      if (flush_now) begin
        flush_pc_o <= head_ent.pc;
      end

      if (cmp_ok) begin
        done_q[cmp_id_i] <= 1'b1;
      end

      // Alloc and commit never target the same slot: that would need count==HF_SIZE, where alloc is refused.
      if (alloc_ok) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end
      if (commit_now) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end

      if (flush_now) begin
        valid_q <= '0;
        head_q  <= head_q + 1'b1;
        tail_q  <= head_q + 1'b1;
        count_q <= '0;
      end else if (alloc_ok && !commit_now) begin
        count_q <= count_q + 1'b1;
      end else if (!alloc_ok && commit_now) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_segre_history_file.sv
// Bench for segre_history_file: a directed vector table, hand-written corner sequences, and random traffic
// checked every cycle against a queue-based model of in-order retirement.
module tb_segre_history_file;

  localparam int WS = 32;
  localparam int RS = 5;
  localparam int HP = 3;
  localparam int HS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rsn = 1'b0;
  logic          alloc_valid = 1'b0;
  logic          cmp_valid = 1'b0;
  logic [HP-1:0] cmp_id = '0;
  logic          cmp_rf_we = 1'b0;
  logic [RS-1:0] cmp_rf_waddr = '0;
  logic [WS-1:0] cmp_res = '0;
  logic          cmp_branch = 1'b0;
  logic          cmp_tkbr = 1'b0;
  logic [WS-1:0] cmp_new_pc = '0;

  logic [HP-1:0] alloc_id_o;
  logic          full_o;
  logic          rf_we_o;
  logic [RS-1:0] rf_waddr_o;
  logic [WS-1:0] rf_wdata_o;
  logic          commit_valid_o;
  logic [HP-1:0] commit_id_o;
  logic          flush_o;
  logic [WS-1:0] flush_pc_o;
  logic          empty_o;

  segre_history_file #(.WORD_SIZE(WS), .REG_SIZE(RS), .HF_PTR(HP)) dut (
    .clk_i(clk), .rsn_i(rsn),
    .alloc_valid_i(alloc_valid), .alloc_id_o(alloc_id_o), .full_o(full_o),
    .cmp_valid_i(cmp_valid), .cmp_id_i(cmp_id), .cmp_rf_we_i(cmp_rf_we),
    .cmp_rf_waddr_i(cmp_rf_waddr), .cmp_res_i(cmp_res), .cmp_branch_i(cmp_branch),
    .cmp_tkbr_i(cmp_tkbr), .cmp_new_pc_i(cmp_new_pc),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o),
    .flush_o(flush_o), .flush_pc_o(flush_pc_o), .empty_o(empty_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: ordered list of live IDs plus per-ID completion records.
  int            mq[$];
  bit            m_inq  [HS];
  bit            m_done [HS];
  bit            m_we   [HS];
  logic [RS-1:0] m_wa   [HS];
  logic [WS-1:0] m_res  [HS];
  bit            m_br   [HS];
  bit            m_tk   [HS];
  logic [WS-1:0] m_pc   [HS];
  int            m_next = 0;

  int            commits_of [HS];
  int            flushes = 0;
  logic [WS-1:0] last_flush_pc = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < HS; i++) commits_of[i] = 0;
    flushes = 0;
    last_flush_pc = '0;
  endtask

  // One clock: predict from the pre-edge model state, advance, then compare after the edge.
  task automatic cycle();
    bit            rst = !rsn;
    bit            e_cv = 0;
    bit            e_we = 0;
    bit            e_fl = 0;
    int            e_cid = 0;
    logic [RS-1:0] e_wa = '0;
    logic [WS-1:0] e_wd = '0;
    logic [WS-1:0] e_pc = '0;
    if (rst) begin
      mq.delete();
      for (int i = 0; i < HS; i++) begin m_inq[i] = 0; m_done[i] = 0; end
      m_next = 0;
    end else begin
      bit commit, flush, full, a_ok, c_ok;
      int h;
      commit = (mq.size() > 0) && m_done[mq[0]];
      h      = commit ? mq[0] : 0;
      flush  = commit && m_br[h] && m_tk[h];
      full   = (mq.size() == HS);
      a_ok   = alloc_valid && !full && !flush;
      c_ok   = cmp_valid && m_inq[cmp_id] && !flush;
      if (commit) begin
        e_cv = 1; e_cid = h; e_we = m_we[h]; e_wa = m_wa[h]; e_wd = m_res[h];
        void'(mq.pop_front());
        m_inq[h] = 0;
      end
      if (flush) begin
        e_fl = 1; e_pc = m_pc[h];
        mq.delete();
        for (int i = 0; i < HS; i++) m_inq[i] = 0;
        m_next = (h + 1) % HS;
      end
      if (c_ok) begin
        m_we[cmp_id] = cmp_rf_we; m_wa[cmp_id] = cmp_rf_waddr; m_res[cmp_id] = cmp_res;
        m_br[cmp_id] = cmp_branch; m_tk[cmp_id] = cmp_tkbr; m_pc[cmp_id] = cmp_new_pc;
        m_done[cmp_id] = 1;
      end
      if (a_ok) begin
        mq.push_back(m_next);
        m_inq[m_next] = 1; m_done[m_next] = 0;
        m_next = (m_next + 1) % HS;
      end
    end
    @(posedge clk);
    #1;
    chk("commit_valid", 64'(commit_valid_o), 64'(e_cv));
    chk("rf_we", 64'(rf_we_o), 64'(e_we));
    chk("flush", 64'(flush_o), 64'(e_fl));
    chk("empty", 64'(empty_o), 64'(mq.size() == 0));
    chk("full", 64'(full_o), 64'(mq.size() == HS));
    chk("alloc_id", 64'(alloc_id_o), 64'(m_next));
    if (rst || e_cv) begin
      chk("commit_id", 64'(commit_id_o), 64'(e_cid));
      chk("rf_waddr", 64'(rf_waddr_o), 64'(e_wa));
      chk("rf_wdata", 64'(rf_wdata_o), 64'(e_wd));
    end
    if (rst || e_fl) chk("flush_pc", 64'(flush_pc_o), 64'(e_pc));
    if (commit_valid_o) commits_of[commit_id_o]++;
    if (flush_o) begin flushes++; last_flush_pc = flush_pc_o; end
  endtask

  task automatic idle();
    alloc_valid = 0; cmp_valid = 0; cmp_branch = 0; cmp_tkbr = 0;
  endtask

  task automatic set_cmp(input int id, input bit we, input int wa, input logic [WS-1:0] res,
                         input bit br, input bit tk, input logic [WS-1:0] pc);
    cmp_valid = 1; cmp_id = HP'(id); cmp_rf_we = we; cmp_rf_waddr = RS'(wa);
    cmp_res = res; cmp_branch = br; cmp_tkbr = tk; cmp_new_pc = pc;
  endtask

  task automatic do_reset();
    rsn = 0; alloc_valid = 1; cmp_valid = 1; cmp_id = '0;
    cycle();
    rsn = 1;
    idle();
    clear_stats();
  endtask

  typedef struct {
    bit            alloc;
    bit            cmp;
    int            id;
    int            wa;
    logic [WS-1:0] res;
    bit            cv;
    int            cid;
    bit            we;
    int            ewa;
    logic [WS-1:0] ewd;
    bit            empty;
    int            aid;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int cand[$];
    int pick;
    int r;

    tbl[0] = '{1, 0, 0, 0, 32'h0,  0, 0, 0, 0, 32'h0,  0, 1};
    tbl[1] = '{1, 0, 0, 0, 32'h0,  0, 0, 0, 0, 32'h0,  0, 2};
    tbl[2] = '{1, 0, 0, 0, 32'h0,  0, 0, 0, 0, 32'h0,  0, 3};
    tbl[3] = '{0, 1, 2, 3, 32'h30, 0, 0, 0, 0, 32'h0,  0, 3};
    tbl[4] = '{0, 1, 1, 2, 32'h20, 0, 0, 0, 0, 32'h0,  0, 3};
    tbl[5] = '{0, 1, 0, 1, 32'h10, 0, 0, 0, 0, 32'h0,  0, 3};
    tbl[6] = '{0, 0, 0, 0, 32'h0,  1, 0, 1, 1, 32'h10, 0, 3};
    tbl[7] = '{0, 0, 0, 0, 32'h0,  1, 1, 1, 2, 32'h20, 0, 3};
    tbl[8] = '{0, 0, 0, 0, 32'h0,  1, 2, 1, 3, 32'h30, 1, 3};
    tbl[9] = '{0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 32'h0,  1, 3};

    // Reset state
    do_reset();
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_alloc_id", 64'(alloc_id_o), 64'd0);

    // Out-of-order completion, in-order retirement
    for (int i = 0; i < 10; i++) begin
      idle();
      alloc_valid = tbl[i].alloc;
      if (tbl[i].cmp) set_cmp(tbl[i].id, 1, tbl[i].wa, tbl[i].res, 0, 0, '0);
      cycle();
      chk($sformatf("v%0d_cv", i), 64'(commit_valid_o), 64'(tbl[i].cv));
      chk($sformatf("v%0d_we", i), 64'(rf_we_o), 64'(tbl[i].we));
      if (tbl[i].cv) begin
        chk($sformatf("v%0d_cid", i), 64'(commit_id_o), 64'(tbl[i].cid));
        chk($sformatf("v%0d_wa", i), 64'(rf_waddr_o), 64'(tbl[i].ewa));
        chk($sformatf("v%0d_wd", i), 64'(rf_wdata_o), 64'(tbl[i].ewd));
      end
      chk($sformatf("v%0d_empty", i), 64'(empty_o), 64'(tbl[i].empty));
      chk($sformatf("v%0d_aid", i), 64'(alloc_id_o), 64'(tbl[i].aid));
    end

    // Fill, drop when full, refuse alloc on the commit cycle, then wrap
    do_reset();
    alloc_valid = 1;
    repeat (8) cycle();
    chk("fill_full", 64'(full_o), 64'd1);
    cycle();
    chk("ninth_dropped_aid", 64'(alloc_id_o), 64'd0);
    chk("ninth_full", 64'(full_o), 64'd1);
    idle();
    set_cmp(0, 1, 7, 32'hABCD, 0, 0, '0);
    cycle();
    idle();
    alloc_valid = 1;
    cycle();
    chk("bound_commit", 64'(commit_valid_o), 64'd1);
    chk("bound_full_clear", 64'(full_o), 64'd0);
    chk("bound_aid", 64'(alloc_id_o), 64'd0);
    cycle();
    chk("wrap_full", 64'(full_o), 64'd1);
    chk("wrap_aid", 64'(alloc_id_o), 64'd1);

    // Taken branch retires and flushes younger entries
    do_reset();
    alloc_valid = 1;
    repeat (4) cycle();
    idle();
    set_cmp(0, 1, 1, 32'hA, 0, 0, '0);                 cycle();
    set_cmp(1, 1, 31, 32'h44, 1, 1, 32'h100);          cycle();
    set_cmp(2, 1, 2, 32'hB, 0, 0, '0);                 cycle();
    set_cmp(3, 1, 3, 32'hC, 0, 0, '0);                 cycle();
    idle();
    repeat (3) cycle();
    chk("br_commit0", 64'(commits_of[0]), 64'd1);
    chk("br_commit1", 64'(commits_of[1]), 64'd1);
    chk("br_no_commit2", 64'(commits_of[2]), 64'd0);
    chk("br_no_commit3", 64'(commits_of[3]), 64'd0);
    chk("br_flushes", 64'(flushes), 64'd1);
    chk("br_flush_pc", 64'(last_flush_pc), 64'h100);
    chk("br_empty", 64'(empty_o), 64'd1);
    chk("br_aid", 64'(alloc_id_o), 64'd2);

    // Completion to an unallocated ID
    do_reset();
    alloc_valid = 1;
    repeat (2) cycle();
    idle();
    set_cmp(5, 1, 9, 32'hDEAD, 1, 1, 32'h55);
    cycle();
    idle();
    repeat (3) cycle();
    chk("inv_no_commit", 64'(commits_of[0] + commits_of[1] + commits_of[5]), 64'd0);
    chk("inv_empty", 64'(empty_o), 64'd0);
    chk("inv_aid", 64'(alloc_id_o), 64'd2);

    // Reset with work pending and a commit due
    do_reset();
    alloc_valid = 1;
    repeat (4) cycle();
    idle();
    set_cmp(0, 1, 4, 32'h77, 0, 0, '0);
    cycle();
    rsn = 0; alloc_valid = 1;
    set_cmp(1, 1, 5, 32'h88, 0, 0, '0);
    cycle();
    chk("mid_rst_cv", 64'(commit_valid_o), 64'd0);
    chk("mid_rst_we", 64'(rf_we_o), 64'd0);
    chk("mid_rst_wa", 64'(rf_waddr_o), 64'd0);
    chk("mid_rst_wd", 64'(rf_wdata_o), 64'd0);
    chk("mid_rst_flush", 64'(flush_o), 64'd0);
    chk("mid_rst_empty", 64'(empty_o), 64'd1);
    chk("mid_rst_aid", 64'(alloc_id_o), 64'd0);
    rsn = 1;
    idle();
    cycle();
    chk("post_rst_no_commit", 64'(commit_valid_o), 64'd0);

    // Streaming: one alloc, one completion, one commit per cycle
    do_reset();
    for (int k = 0; k < 23; k++) begin
      idle();
      alloc_valid = 1;
      for (int i = 0; i < mq.size(); i++) begin
        if (!m_done[mq[i]]) begin
          set_cmp(mq[i], 1, k % 32, WS'(k * 3 + 1), 0, 0, '0);
          break;
        end
      end
      cycle();
      if (k >= 3) begin
        chk("stream_cv", 64'(commit_valid_o), 64'd1);
        chk("stream_count", 64'((alloc_id_o - commit_id_o - 3'd1) & 3'h7), 64'd2);
      end
    end

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      idle();
      rsn = ($urandom_range(0, 199) != 0);
      alloc_valid = ($urandom_range(0, 2) != 0);
      cand.delete();
      r = $urandom_range(0, 9);
      if (r < 7) begin
        for (int i = 0; i < mq.size(); i++) if (!m_done[mq[i]]) cand.push_back(mq[i]);
      end else if (r < 8) begin
        for (int i = 0; i < HS; i++) if (!m_inq[i]) cand.push_back(i);
      end
      if (cand.size() > 0) begin
        pick = cand[$urandom_range(0, cand.size() - 1)];
        set_cmp(pick, $urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom(),
                $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom());
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
